// File: rtl/xentry_pkg.sv
// Shared type definitions for the memory request interfaces.
//
// memory_operation_e : kind of a word request (LOAD or STORE)
package xentry_pkg;

    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } memory_operation_e;

endpackage

// File: rtl/l2_responder.sv
// l2_responder: fixed-latency word-wide L2 memory model.
//
// Accepts one word request at a time, waits a programmable number of cycles
// and then completes it with a one-cycle fulfilled pulse.
// Loads return the addressed word.
// Stores write the latched data into the backing store.
//
// Parameters
//   XLEN      : data and address width in bits
//   MEM_WORDS : backing-store depth in XLEN-bit words (power of two, >= 2)
//   LATENCY   : cycles from request acceptance to the fulfilled pulse (>= 1)
//
// Ports
//   clk              : rising-edge clock
//   reset            : synchronous active-high reset
//   l2_req_valid     : requester holds a word request
//   l2_req_type      : LOAD or STORE
//   l2_req_address   : byte address of the requested word
//   l2_word_to_store : store data
//   l2_fetched_word  : load data, held until the next load completes
//   l2_req_fulfilled : one-cycle completion pulse
//   l2_busy          : high whenever a request is in flight
//
// Optional feature, enabled by defining the macro L2_RESPONDER_STATS_EN:
//   load_count       : saturating count of fulfilled loads
//   store_count      : saturating count of fulfilled stores
module l2_responder #(
    parameter int XLEN      = 32,
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         l2_req_valid,
    input  xentry_pkg::memory_operation_e l2_req_type,
    input  logic [XLEN-1:0]              l2_req_address,
    input  logic [XLEN-1:0]              l2_word_to_store,
    output logic [XLEN-1:0]              l2_fetched_word,
    output logic                         l2_req_fulfilled,
    output logic                         l2_busy
`ifdef L2_RESPONDER_STATS_EN
    ,
    output logic [31:0]                  load_count,
    output logic [31:0]                  store_count
`endif
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    // The counter holds at most LATENCY-1, which fits in clog2(LATENCY) bits.
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    if (LATENCY < 1) begin : g_bad_latency
        $error("l2_responder: LATENCY must be at least 1");
    end
    if ((MEM_WORDS < 2) || ((MEM_WORDS & (MEM_WORDS - 1)) != 0)) begin : g_bad_depth
        $error("l2_responder: MEM_WORDS must be a power of two and at least 2");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                        state;
    logic [CNT_W-1:0]              wait_count;
    logic [IDX_W-1:0]              lat_index;
    xentry_pkg::memory_operation_e lat_type;
    logic [XLEN-1:0]               lat_data;

    // Backing store starts out all zeros and is never touched by reset.
    logic [XLEN-1:0] mem [MEM_WORDS] = '{default: '0};

    // Byte address to word index: the low two bits select a byte within the
    // word and are dropped; bits above the index alias modulo MEM_WORDS.
    logic [IDX_W-1:0] req_index;
    assign req_index = l2_req_address[IDX_W+1:2];

    logic unused_address_bits;
    assign unused_address_bits = ^{l2_req_address[XLEN-1:IDX_W+2], l2_req_address[1:0]};

    // Request sequencer. Outputs are registered and updated on the edge that
    // enters each state, so l2_req_fulfilled and l2_fetched_word appear in
    // the DONE cycle itself. With LATENCY=1 there are no WAIT cycles and the
    // sequencer jumps straight from IDLE to DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            wait_count       <= '0;
            l2_req_fulfilled <= 1'b0;
            l2_busy          <= 1'b0;
            l2_fetched_word  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    l2_req_fulfilled <= 1'b0;
                    if (l2_req_valid) begin
                        lat_index <= req_index;
                        lat_type  <= l2_req_type;
                        lat_data  <= l2_word_to_store;
                        l2_busy   <= 1'b1;
                        if (LATENCY == 1) begin
                            state            <= DONE;
                            l2_req_fulfilled <= 1'b1;
                            if (l2_req_type == xentry_pkg::LOAD) begin
                                l2_fetched_word <= mem[req_index];
                            end
                        end else begin
                            state      <= WAIT;
                            wait_count <= CNT_W'(LATENCY - 1);
                        end
                    end
                end

                // The counter reaching zero on this edge means the next
                // cycle is cycle N+LATENCY, so DONE is entered now.
                WAIT: begin
                    wait_count <= wait_count - CNT_W'(1);
                    if (wait_count == CNT_W'(1)) begin
                        state            <= DONE;
                        l2_req_fulfilled <= 1'b1;
                        if (lat_type == xentry_pkg::LOAD) begin
                            l2_fetched_word <= mem[lat_index];
                        end
                    end
                end

                DONE: begin
                    state            <= IDLE;
                    l2_req_fulfilled <= 1'b0;
                    l2_busy          <= 1'b0;
                end

                default: begin
                    state            <= IDLE;
                    l2_req_fulfilled <= 1'b0;
                    l2_busy          <= 1'b0;
                end
            endcase
        end
    end

    // Store commit happens at the end of the DONE cycle; a reset in that
    // cycle aborts the request, so the write is suppressed.
    always_ff @(posedge clk) begin
        if (!reset && (state == DONE) && (lat_type == xentry_pkg::STORE)) begin
            mem[lat_index] <= lat_data;
        end
    end

`ifdef L2_RESPONDER_STATS_EN
    // Saturating per-type completion counters, one step per DONE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_count  <= '0;
            store_count <= '0;
        end else if (state == DONE) begin
            if ((lat_type == xentry_pkg::LOAD) && (load_count != '1)) begin
                load_count <= load_count + 32'd1;
            end
            if ((lat_type == xentry_pkg::STORE) && (store_count != '1)) begin
                store_count <= store_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_l2_responder.sv
// Directed testbench for l2_responder with XLEN=32, MEM_WORDS=1024, LATENCY=2.
// Expected values are hand-computed constants.
module tb_l2_responder;
    import xentry_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              l2_req_valid;
    memory_operation_e l2_req_type;
    logic [31:0]       l2_req_address;
    logic [31:0]       l2_word_to_store;
    logic [31:0]       l2_fetched_word;
    logic              l2_req_fulfilled;
    logic              l2_busy;
`ifdef L2_RESPONDER_STATS_EN
    logic [31:0]       load_count;
    logic [31:0]       store_count;
`endif

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;

    l2_responder #(
        .XLEN(32),
        .MEM_WORDS(1024),
        .LATENCY(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .l2_req_valid(l2_req_valid),
        .l2_req_type(l2_req_type),
        .l2_req_address(l2_req_address),
        .l2_word_to_store(l2_word_to_store),
        .l2_fetched_word(l2_fetched_word),
        .l2_req_fulfilled(l2_req_fulfilled),
        .l2_busy(l2_busy)
`ifdef L2_RESPONDER_STATS_EN
        ,
        .load_count(load_count),
        .store_count(store_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle = cycle + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared = compared + 1;
        assert (observed === expected) else begin
            mismatched = mismatched + 1;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete request with valid dropped and the address scrambled
    // right after acceptance; the latched request must still complete.
    task automatic applyStimulus(input memory_operation_e op, input logic [31:0] addr,
                                 input logic [31:0] data, input string tag);
        int accept_cycle;
        l2_req_valid     = 1'b1;
        l2_req_type      = op;
        l2_req_address   = addr;
        l2_word_to_store = data;
        tick();
        accept_cycle = cycle;
        checkOutput({tag, " busy after accept"}, {31'd0, l2_busy}, 32'd1);
        checkOutput({tag, " no early pulse"}, {31'd0, l2_req_fulfilled}, 32'd0);
        l2_req_valid     = 1'b0;
        l2_req_address   = ~addr;
        l2_word_to_store = ~data;
        tick();
        checkOutput({tag, " pulse"}, {31'd0, l2_req_fulfilled}, 32'd1);
        checkOutput({tag, " pulse latency"}, 32'(cycle - accept_cycle), 32'd1);
        tick();
        checkOutput({tag, " pulse ends"}, {31'd0, l2_req_fulfilled}, 32'd0);
        checkOutput({tag, " idle busy"}, {31'd0, l2_busy}, 32'd0);
    endtask

    initial begin
        int last_pulse;
        bit found;

        reset            = 1'b1;
        l2_req_valid     = 1'b0;
        l2_req_type      = LOAD;
        l2_req_address   = '0;
        l2_word_to_store = '0;
        tick();
        tick();
        checkOutput("reset fulfilled", {31'd0, l2_req_fulfilled}, 32'd0);
        checkOutput("reset busy", {31'd0, l2_busy}, 32'd0);
        checkOutput("reset fetched", l2_fetched_word, 32'd0);
        reset = 1'b0;
        tick();

        // Store then immediately load the same word.
        applyStimulus(STORE, 32'h40, 32'hDEADBEEF, "store40");
        checkOutput("store leaves fetched", l2_fetched_word, 32'd0);
        applyStimulus(LOAD, 32'h40, 32'h0, "load40");
        checkOutput("load40 data held", l2_fetched_word, 32'hDEADBEEF);

        // Fill words 0..7, then read them back as a descending line fill
        // with valid held high the whole time.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(STORE, 32'(i * 4), 32'h1000 + 32'(i), "fillstore");
        end
        l2_req_valid = 1'b1;
        l2_req_type  = LOAD;
        last_pulse   = 0;
        for (int k = 0; k < 8; k++) begin
            l2_req_address = 32'h1C - 32'(4 * k);
            found = 1'b0;
            for (int w = 0; w < 8 && !found; w++) begin
                tick();
                if (l2_req_fulfilled) found = 1'b1;
            end
            checkOutput("linefill pulse seen", {31'd0, found}, 32'd1);
            if (k > 0) begin
                checkOutput("linefill spacing", 32'(cycle - last_pulse), 32'd3);
            end
            last_pulse = cycle;
            checkOutput("linefill data", l2_fetched_word, 32'h1000 + 32'(7 - k));
        end
        l2_req_valid = 1'b0;
        tick();
        checkOutput("linefill idle", {31'd0, l2_busy}, 32'd0);

        // Upper address bits alias, low two bits are ignored.
        applyStimulus(STORE, 32'h1000, 32'h12345678, "alias store");
        applyStimulus(LOAD, 32'h0, 32'h0, "alias load0");
        checkOutput("alias data 0x0", l2_fetched_word, 32'h12345678);
        applyStimulus(LOAD, 32'h3, 32'h0, "alias load3");
        checkOutput("alias data 0x3", l2_fetched_word, 32'h12345678);

        // Reset during WAIT of a store aborts it without writing.
        applyStimulus(STORE, 32'h80, 32'h0BADF00D, "prior store80");
        l2_req_valid     = 1'b1;
        l2_req_type      = STORE;
        l2_req_address   = 32'h80;
        l2_word_to_store = 32'hAAAA5555;
        tick();
        checkOutput("abort busy in wait", {31'd0, l2_busy}, 32'd1);
        l2_req_valid = 1'b0;
        reset        = 1'b1;
        tick();
        checkOutput("abort busy", {31'd0, l2_busy}, 32'd0);
        checkOutput("abort no pulse", {31'd0, l2_req_fulfilled}, 32'd0);
        checkOutput("abort fetched", l2_fetched_word, 32'd0);
        reset = 1'b0;
        tick();
        checkOutput("abort still no pulse", {31'd0, l2_req_fulfilled}, 32'd0);
        applyStimulus(LOAD, 32'h80, 32'h0, "load80");
        checkOutput("abort kept old data", l2_fetched_word, 32'h0BADF00D);

        // Valid held through DONE must not be re-accepted until IDLE.
        l2_req_valid     = 1'b1;
        l2_req_type      = STORE;
        l2_req_address   = 32'h44;
        l2_word_to_store = 32'h55;
        tick();
        checkOutput("hold busy", {31'd0, l2_busy}, 32'd1);
        tick();
        checkOutput("hold pulse", {31'd0, l2_req_fulfilled}, 32'd1);
        tick();
        checkOutput("hold back to idle", {31'd0, l2_busy}, 32'd0);
        checkOutput("hold no second pulse", {31'd0, l2_req_fulfilled}, 32'd0);
        l2_req_valid = 1'b0;
        tick();
        checkOutput("hold not accepted", {31'd0, l2_busy}, 32'd0);
        applyStimulus(LOAD, 32'h44, 32'h0, "load44");
        checkOutput("hold data", l2_fetched_word, 32'h55);

`ifdef L2_RESPONDER_STATS_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        applyStimulus(LOAD, 32'h0, 32'h0, "stat load a");
        applyStimulus(STORE, 32'h8, 32'h77, "stat store a");
        applyStimulus(LOAD, 32'h4, 32'h0, "stat load b");
        applyStimulus(STORE, 32'hC, 32'h88, "stat store b");
        applyStimulus(LOAD, 32'h8, 32'h0, "stat load c");
        checkOutput("load_count", load_count, 32'd3);
        checkOutput("store_count", store_count, 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("load_count reset", load_count, 32'd0);
        checkOutput("store_count reset", store_count, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/l2_responder.md
L2_RESPONDER -- requirements
Module: l2_responder

Interface
REQ-001 SHALL have parameter XLEN, default 32: data and address width in bits.
REQ-002 SHALL have parameter MEM_WORDS, default 1024: backing-store depth in XLEN-bit words; power of two, at least 2.
REQ-003 SHALL have parameter LATENCY, default 2: cycles from request acceptance to fulfilment; LATENCY >= 1, elaboration error otherwise.
REQ-004 SHALL have port clk, input, 1: single clock, all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-006 SHALL have port l2_req_valid, input, 1: requester holds a word request.
REQ-007 SHALL have port l2_req_type, input, memory_operation_e (xentry_pkg): LOAD or STORE.
REQ-008 SHALL have port l2_req_address, input, XLEN: byte address of the requested word.
REQ-009 SHALL have port l2_word_to_store, input, XLEN: store data.
REQ-010 SHALL have port l2_fetched_word, output, XLEN: load data.
REQ-011 SHALL have port l2_req_fulfilled, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port l2_busy, output, 1: high in every state other than IDLE.

Function
REQ-013 SHALL implement the states IDLE, WAIT and DONE.
REQ-014 SHALL, in IDLE with l2_req_valid=1 (acceptance cycle N), latch address, type and store data, load the wait counter with LATENCY-1, and go to WAIT.
REQ-015 SHALL, in WAIT, decrement the counter each cycle and go to DONE when it reaches 0, so that l2_req_fulfilled=1 exactly in cycle N+LATENCY.
REQ-016 SHALL hold l2_req_fulfilled high only in DONE, and SHALL always leave DONE for IDLE after one cycle.
REQ-017 SHALL ignore l2_req_valid in WAIT and DONE, so the next request is accepted no earlier than cycle N+LATENCY+1 (back-to-back spacing LATENCY+1).
REQ-018 SHALL use word index = latched address[$clog2(MEM_WORDS)+1:2]; address bits [1:0] are ignored and higher bits alias modulo MEM_WORDS.
REQ-019 SHALL, for a LOAD, drive l2_fetched_word with mem[index] in the DONE cycle and hold that value until the next LOAD completes.
REQ-020 SHALL, for a STORE, write the latched data to mem[index] at the end of the DONE cycle; l2_fetched_word is unchanged.
REQ-021 SHALL complete a latched request even if l2_req_valid drops or the address changes during WAIT.
REQ-022 SHALL return to a LOAD accepted right after a STORE to the same index the newly stored data.

Reset
REQ-023 SHALL, when reset=1, enter IDLE and drive l2_req_fulfilled=0, l2_busy=0 and l2_fetched_word=0 on the next edge.
REQ-024 SHALL, on reset during WAIT or DONE, abort the request with no memory write and no fulfilled pulse.
REQ-025 SHALL NOT change memory contents on reset; memory SHALL initialise to all zeros at time 0.

Configuration
REQ-026 SHALL, with macro L2_RESPONDER_STATS_EN defined, add outputs load_count and store_count (32 bits each), which increment once per fulfilled LOAD and STORE respectively, saturate at all-ones, and clear on reset.
REQ-027 SHALL, without L2_RESPONDER_STATS_EN, have neither port nor counter logic; all other behaviour SHALL be identical.

Verification
REQ-028 SHALL cover: LATENCY=2, STORE 0xDEADBEEF to 0x40 accepted at cycle 10 -> fulfilled pulse at cycle 12 only; then LOAD 0x40 -> fetched 0xDEADBEEF at cycle 15.
REQ-029 SHALL cover: eight-word line fill with the address descending 0x1C..0x00 and valid held high -> eight fulfilled pulses spaced 3 cycles apart, data in matching order.
REQ-030 SHALL cover: MEM_WORDS=1024, STORE 0x12345678 to 0x1000 then LOAD 0x0 -> 0x12345678 (aliasing); LOAD 0x3 -> same word as 0x0.
REQ-031 SHALL cover: reset asserted in WAIT of a STORE of 0xAAAA5555 to 0x80 -> no pulse, l2_busy=0 next cycle, later LOAD 0x80 returns prior contents.
REQ-032 SHALL cover: valid dropped during WAIT -> pulse still at N+LATENCY; valid held through DONE with the old address -> no duplicate acceptance until IDLE.
REQ-033 SHALL cover: with L2_RESPONDER_STATS_EN, 3 LOADs and 2 STOREs -> load_count=3, store_count=2; reset -> both 0.
